// File: rtl/aurora_rx_pkg.sv
// aurora_rx_pkg: shared constants and types for the Aurora 64b/66b RX lane.
//   HDR_DATA / HDR_CTRL : the two legal sync header encodings.
//   sync_state_t        : block-lock FSM states (HUNT, WAIT, LOCKED).
//   hdr_good()          : true when a sync header is one of the legal encodings.
package aurora_rx_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    WAIT   = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  function automatic logic hdr_good(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/aurora_sync_window.sv
// aurora_sync_window: bad-header window counter used while block-locked.
//   clk_rx_i, rst_i : lane clock, synchronous active-high reset.
//   en_i            : high while locked; low clears both counters.
//   hdr_valid_i     : a header is presented this cycle.
//   hdr_bad_i       : the presented header is illegal.
//   lose_lock_o     : combinational; this header is the BAD_MAX-th bad one
//                     inside the current window.
module aurora_sync_window #(
  parameter int WIN_LEN = 1024,
  parameter int BAD_MAX = 16
) (
  input  logic clk_rx_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hdr_valid_i,
  input  logic hdr_bad_i,
  output logic lose_lock_o
);

  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam int BAD_W = $clog2(BAD_MAX + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(BAD_MAX - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;

  // Threshold is checked before the wrap, so a BAD_MAX-th bad header on the
  // last window slot still drops lock.
  assign lose_lock_o = en_i && hdr_valid_i && hdr_bad_i && (bad_cnt_q == BAD_LAST);

  always_comb begin
    win_cnt_d = win_cnt_q;
    bad_cnt_d = bad_cnt_q;
    if (!en_i || lose_lock_o) begin
      win_cnt_d = '0;
      bad_cnt_d = '0;
    end else if (hdr_valid_i) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d = '0;
        bad_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (hdr_bad_i) bad_cnt_d = bad_cnt_q + BAD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      win_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

endmodule

// File: rtl/aurora_block_sync_ctrl.sv
// aurora_block_sync_ctrl: block-lock controller for an Aurora 64b/66b RX lane.
// Hunts for sync-header alignment by pulsing gearbox slips, escalates to a
// SERDES bitslip after MAX_SLIPS unsuccessful slips, and tracks lock quality
// with a bad-header window once locked.
//   clk_rx_i, rst_i  : lane clock, synchronous active-high reset.
//   header_i         : 2-bit sync header from the gearbox.
//   header_valid_i   : header_i qualifies this cycle.
//   slip_o           : one-cycle gearbox slip request.
//   serdes_slip_o    : one-cycle SERDES bitslip request.
//   locked_o         : block lock achieved.
//   stat_o           : {locked, serdes-slip sticky, lock-loss count[5:0]} when
//                      AURORA_SYNC_STATS_EN is defined, else {locked, 7'b0}.
module aurora_block_sync_ctrl
  import aurora_rx_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_LEN   = 1024,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 16,
  parameter int MAX_SLIPS = 66
) (
  input  logic       clk_rx_i,
  input  logic       rst_i,
  input  logic [1:0] header_i,
  input  logic       header_valid_i,
  output logic       slip_o,
  output logic       serdes_slip_o,
  output logic       locked_o,
  output logic [7:0] stat_o
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int SLIP_W = $clog2(MAX_SLIPS + 1);
  localparam int WAIT_W = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(MAX_SLIPS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  sync_state_t       state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              slip_q, slip_d;
  logic              serdes_slip_q, serdes_slip_d;
  logic              locked_q, locked_d;
  logic              hdr_bad;
  logic              lose_lock;

  assign hdr_bad = !hdr_good(header_i);

  aurora_sync_window #(
    .WIN_LEN (WIN_LEN),
    .BAD_MAX (BAD_MAX)
  ) u_win (
    .clk_rx_i    (clk_rx_i),
    .rst_i       (rst_i),
    .en_i        (state_q == LOCKED),
    .hdr_valid_i (header_valid_i),
    .hdr_bad_i   (hdr_bad),
    .lose_lock_o (lose_lock)
  );

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    slip_cnt_d    = slip_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    slip_d        = 1'b0;
    serdes_slip_d = 1'b0;
    locked_d      = locked_q;
    case (state_q)
      HUNT: begin
        if (header_valid_i) begin
          if (!hdr_bad) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              slip_cnt_d = '0;
              locked_d   = 1'b1;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
            wait_cnt_d = '0;
            // With no settle time there is nothing to wait for.
            state_d    = (SLIP_WAIT < 1) ? HUNT : WAIT;
            if (slip_cnt_q == SLIP_LAST) begin
              serdes_slip_d = 1'b1;
              slip_cnt_d    = '0;
            end else begin
              slip_d     = 1'b1;
              slip_cnt_d = slip_cnt_q + SLIP_W'(1);
            end
          end
        end
      end
      // Gearbox output is unsettled after a slip; headers are ignored here.
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HUNT;
          wait_cnt_d = '0;
          good_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      LOCKED: begin
        // No slip on loss of lock; the next bad header in HUNT slips.
        if (lose_lock) begin
          state_d    = HUNT;
          good_cnt_d = '0;
          slip_cnt_d = '0;
          wait_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
      default: begin
        state_d  = HUNT;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      state_q       <= HUNT;
      good_cnt_q    <= '0;
      slip_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      slip_q        <= 1'b0;
      serdes_slip_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      slip_cnt_q    <= slip_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      slip_q        <= slip_d;
      serdes_slip_q <= serdes_slip_d;
      locked_q      <= locked_d;
    end
  end

  assign slip_o        = slip_q;
  assign serdes_slip_o = serdes_slip_q;
  assign locked_o      = locked_q;

`ifdef AURORA_SYNC_STATS_EN
  logic       sticky_q, sticky_d;
  logic [5:0] loss_q, loss_d;

  always_comb begin
    sticky_d = sticky_q | serdes_slip_d;
    loss_d   = loss_q;
    if (state_q == LOCKED && lose_lock && loss_q != 6'd63) loss_d = loss_q + 6'd1;
  end

  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
      loss_q   <= '0;
    end else begin
      sticky_q <= sticky_d;
      loss_q   <= loss_d;
    end
  end

  assign stat_o = {locked_q, sticky_q, loss_q};
`else
  assign stat_o = {locked_q, 7'b0};
`endif

endmodule
